// File: rtl/adc_square_shaper_pkg.sv
// rtl/adc_square_shaper_pkg.sv - shared types and helpers for the ADC square shaper
package adc_shaper_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 12;

  typedef logic [DEF_DATA_WIDTH-1:0] sample_t;

  function automatic int unsigned win_log2(input int unsigned n);
    return $clog2(n);
  endfunction

  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned win);
    return dw + win_log2(win);
  endfunction

  // Both helpers work one bit wider so the carry/borrow is visible before clamping.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] max_val);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, max_val}) ? max_val : s[31:0];
  endfunction

  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[32] ? 32'd0 : d[31:0];
  endfunction

endpackage

// File: rtl/adc_square_shaper_if.sv
// rtl/adc_square_shaper_if.sv - sample stream in, shaped square and threshold out
interface adc_square_shaper_if #(
  parameter int DATA_WIDTH = 12
);
  logic                  adc_valid;
  logic [DATA_WIDTH-1:0] adc_data;
  logic                  square_out;
  logic                  edge_pulse;
  logic [DATA_WIDTH-1:0] thr;
  logic                  thr_valid;

  modport master (
    output adc_valid, adc_data,
    input  square_out, edge_pulse, thr, thr_valid
  );

  modport slave (
    input  adc_valid, adc_data,
    output square_out, edge_pulse, thr, thr_valid
  );
endinterface

// File: rtl/adc_square_shaper_window_mean.sv
// rtl/adc_square_shaper_window_mean.sv - block average of AVG_WINDOW samples as threshold
module window_mean
  import adc_shaper_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int AVG_WINDOW = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] thr,
  output logic                  thr_valid
);

  localparam int LOG2W = win_log2(AVG_WINDOW);
  localparam int ACC_W = acc_width(DATA_WIDTH, AVG_WINDOW);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [LOG2W-1:0] cnt;

  assign acc_sum = acc + ACC_W'(data);

  // The mean is a plain shift of the final sum: truncation, no rounding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      thr       <= '0;
      thr_valid <= 1'b0;
    end else if (valid) begin
      if (cnt == LOG2W'(AVG_WINDOW - 1)) begin
        thr       <= acc_sum[ACC_W-1:LOG2W];
        thr_valid <= 1'b1;
        acc       <= '0;
        cnt       <= '0;
      end else begin
        acc <= acc_sum;
        cnt <= cnt + LOG2W'(1);
      end
    end
  end

endmodule

// File: rtl/adc_square_shaper.sv
// rtl/adc_square_shaper.sv - hysteresis comparator and glitch filter producing a square wave
module adc_square_shaper
  import adc_shaper_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int AVG_WINDOW = 1024,
  parameter int HYST       = 16,
  parameter int DEGLITCH   = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  adc_square_shaper_if.slave  bus
);

  localparam int DG_W = (DEGLITCH > 1) ? $clog2(DEGLITCH) : 1;

  logic [DATA_WIDTH-1:0] thr_w;
  logic                  thr_valid_w;
  logic [DATA_WIDTH-1:0] hi, lo;
  logic                  cand;
  logic                  square_q, square_nxt;
  logic                  edge_q, edge_nxt;
  logic [DG_W-1:0]       dg_cnt, dg_nxt;

  window_mean #(
    .DATA_WIDTH (DATA_WIDTH),
    .AVG_WINDOW (AVG_WINDOW)
  ) u_window_mean (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (bus.adc_valid),
    .data      (bus.adc_data),
    .thr       (thr_w),
    .thr_valid (thr_valid_w)
  );

  // Registered thr means the window-completing sample still compares against the old mean.
  always_comb begin
    hi   = DATA_WIDTH'(sat_add(32'(thr_w), 32'(HYST), 32'({DATA_WIDTH{1'b1}})));
    lo   = DATA_WIDTH'(sat_sub(32'(thr_w), 32'(HYST)));
    cand = square_q;
    if (bus.adc_data > hi) begin
      cand = 1'b1;
    end else if (bus.adc_data < lo) begin
      cand = 1'b0;
    end
  end

  always_comb begin
    square_nxt = square_q;
    dg_nxt     = dg_cnt;
    edge_nxt   = 1'b0;
    if (bus.adc_valid && thr_valid_w) begin
      if (cand != square_q) begin
        if (dg_cnt == DG_W'(DEGLITCH - 1)) begin
          square_nxt = ~square_q;
          dg_nxt     = '0;
          edge_nxt   = ~square_q;
        end else begin
          dg_nxt = dg_cnt + DG_W'(1);
        end
      end else begin
        dg_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      square_q <= 1'b0;
      edge_q   <= 1'b0;
      dg_cnt   <= '0;
    end else begin
      square_q <= square_nxt;
      edge_q   <= edge_nxt;
      dg_cnt   <= dg_nxt;
    end
  end

  assign bus.square_out = square_q;
  assign bus.edge_pulse = edge_q;
  assign bus.thr        = thr_w;
  assign bus.thr_valid  = thr_valid_w;

endmodule

// File: tb/tb_adc_square_shaper.sv
// tb/tb_adc_square_shaper.sv - directed self-checking bench for adc_square_shaper
module tb_adc_square_shaper;
  import adc_shaper_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adc_square_shaper_if #(.DATA_WIDTH(12)) bus();

  adc_square_shaper #(
    .DATA_WIDTH (12),
    .AVG_WINDOW (1024),
    .HYST       (16),
    .DEGLITCH   (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int  n_cmp = 0;
  int  n_bad = 0;
  time last_t;
  time rise_t[$];
  time fall_t[$];
  int  dbl_pulse = 0;
  logic prev_sq = 1'b0;
  logic prev_ep = 1'b0;

  always @(negedge clk) begin
    if (bus.edge_pulse) rise_t.push_back($time);
    if (prev_sq && !bus.square_out) fall_t.push_back($time);
    if (prev_ep && bus.edge_pulse) dbl_pulse++;
    prev_sq = bus.square_out;
    prev_ep = bus.edge_pulse;
  end

  task automatic send(input sample_t v, input int gap);
    @(negedge clk);
    bus.adc_valid = 1'b1;
    bus.adc_data  = v;
    last_t        = $time;
    @(negedge clk);
    bus.adc_valid = 1'b0;
    repeat (gap - 2) @(negedge clk);
  endtask

  task automatic send_n(input sample_t v, input int n);
    for (int i = 0; i < n; i++) send(v, 2);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.adc_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic calibrate(input sample_t a, input sample_t b);
    do_reset();
    for (int i = 0; i < 512; i++) begin
      send(a, 2);
      send(b, 2);
    end
  endtask

  task automatic test_reset();
    bus.adc_valid = 1'b0;
    bus.adc_data  = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.square_out !== 1'b0) begin n_bad++; $display("FAIL reset_square: got %b want 0", bus.square_out); end
    n_cmp++; if (bus.edge_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_edge: got %b want 0", bus.edge_pulse); end
    n_cmp++; if (bus.thr !== 12'd0) begin n_bad++; $display("FAIL reset_thr: got %0d want 0", bus.thr); end
    n_cmp++; if (bus.thr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_thr_valid: got %b want 0", bus.thr_valid); end
    rst_n = 1'b1;
  endtask

  task automatic test_calibration();
    logic sq_seen;
    logic tv_early;
    sq_seen  = 1'b0;
    tv_early = 1'b1;
    do_reset();
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      if (bus.square_out) sq_seen = 1'b1;
      if (i == 1023) tv_early = bus.thr_valid;
      bus.adc_valid = 1'b1;
      bus.adc_data  = 12'd2048;
    end
    @(negedge clk);
    bus.adc_valid = 1'b0;
    if (bus.square_out) sq_seen = 1'b1;
    n_cmp++; if (tv_early !== 1'b0) begin n_bad++; $display("FAIL cal_thr_valid_early: got %b want 0", tv_early); end
    n_cmp++; if (bus.thr_valid !== 1'b1) begin n_bad++; $display("FAIL cal_thr_valid: got %b want 1", bus.thr_valid); end
    n_cmp++; if (bus.thr !== 12'd2048) begin n_bad++; $display("FAIL cal_thr: got %0d want 2048", bus.thr); end
    n_cmp++; if (sq_seen !== 1'b0) begin n_bad++; $display("FAIL cal_square_quiet: got %b want 0", sq_seen); end
  endtask

  task automatic test_tracking();
    time in_rise[3];
    time in_fall[3];
    calibrate(12'd1000, 12'd3000);
    n_cmp++; if (bus.thr !== 12'd2000) begin n_bad++; $display("FAIL trk_thr: got %0d want 2000", bus.thr); end
    rise_t.delete();
    fall_t.delete();
    dbl_pulse = 0;
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 20; k++) begin
        send(12'd3000, 20);
        if (k == 0) in_rise[p] = last_t;
      end
      for (int k = 0; k < 20; k++) begin
        send(12'd1000, 20);
        if (k == 0) in_fall[p] = last_t;
      end
    end
    n_cmp++; if (rise_t.size() != 3) begin n_bad++; $display("FAIL trk_pulse_count: got %0d want 3", rise_t.size()); end
    n_cmp++; if (fall_t.size() != 3) begin n_bad++; $display("FAIL trk_fall_count: got %0d want 3", fall_t.size()); end
    n_cmp++; if (dbl_pulse != 0) begin n_bad++; $display("FAIL trk_double_pulse: got %0d want 0", dbl_pulse); end
    for (int p = 0; p < 3 && p < rise_t.size(); p++) begin
      n_cmp++; if (rise_t[p] - in_rise[p] != 410) begin n_bad++; $display("FAIL trk_rise_lag%0d: got %0t want 410", p, rise_t[p] - in_rise[p]); end
    end
    for (int p = 0; p < 3 && p < fall_t.size(); p++) begin
      n_cmp++; if (fall_t[p] - in_fall[p] != 410) begin n_bad++; $display("FAIL trk_fall_lag%0d: got %0t want 410", p, fall_t[p] - in_fall[p]); end
    end
    for (int p = 1; p < rise_t.size(); p++) begin
      n_cmp++; if (rise_t[p] - rise_t[p-1] != 8000) begin n_bad++; $display("FAIL trk_period%0d: got %0t want 8000", p, rise_t[p] - rise_t[p-1]); end
    end
  endtask

  task automatic test_glitch();
    calibrate(12'd1000, 12'd3000);
    send_n(12'd3000, 2);
    n_cmp++; if (bus.square_out !== 1'b0) begin n_bad++; $display("FAIL gl_rise_early: got %b want 0", bus.square_out); end
    send(12'd3000, 2);
    n_cmp++; if (bus.square_out !== 1'b1) begin n_bad++; $display("FAIL gl_rise: got %b want 1", bus.square_out); end
    n_cmp++; if (bus.edge_pulse !== 1'b1) begin n_bad++; $display("FAIL gl_edge_pulse: got %b want 1", bus.edge_pulse); end
    send_n(12'd1000, 2);
    n_cmp++; if (bus.edge_pulse !== 1'b0) begin n_bad++; $display("FAIL gl_edge_clear: got %b want 0", bus.edge_pulse); end
    n_cmp++; if (dut.dg_cnt !== 2'd2) begin n_bad++; $display("FAIL gl_dg_two: got %0d want 2", dut.dg_cnt); end
    send(12'd3000, 2);
    n_cmp++; if (bus.square_out !== 1'b1) begin n_bad++; $display("FAIL gl_hold: got %b want 1", bus.square_out); end
    n_cmp++; if (dut.dg_cnt !== 2'd0) begin n_bad++; $display("FAIL gl_dg_clear: got %0d want 0", dut.dg_cnt); end
    send_n(12'd1000, 2);
    n_cmp++; if (bus.square_out !== 1'b1) begin n_bad++; $display("FAIL gl_fall_early: got %b want 1", bus.square_out); end
    send(12'd1000, 2);
    n_cmp++; if (bus.square_out !== 1'b0) begin n_bad++; $display("FAIL gl_fall: got %b want 0", bus.square_out); end
    n_cmp++; if (bus.edge_pulse !== 1'b0) begin n_bad++; $display("FAIL gl_fall_no_pulse: got %b want 0", bus.edge_pulse); end
  endtask

  task automatic test_hysteresis();
    calibrate(12'd1000, 12'd3000);
    send_n(12'd2016, 3);
    n_cmp++; if (bus.square_out !== 1'b0) begin n_bad++; $display("FAIL hy_2016: got %b want 0", bus.square_out); end
    send_n(12'd1984, 3);
    n_cmp++; if (bus.square_out !== 1'b0) begin n_bad++; $display("FAIL hy_1984_low: got %b want 0", bus.square_out); end
    send_n(12'd2017, 2);
    n_cmp++; if (bus.square_out !== 1'b0) begin n_bad++; $display("FAIL hy_2017_early: got %b want 0", bus.square_out); end
    send(12'd2017, 2);
    n_cmp++; if (bus.square_out !== 1'b1) begin n_bad++; $display("FAIL hy_2017: got %b want 1", bus.square_out); end
    send_n(12'd1984, 3);
    n_cmp++; if (bus.square_out !== 1'b1) begin n_bad++; $display("FAIL hy_1984_high: got %b want 1", bus.square_out); end
    send_n(12'd1983, 3);
    n_cmp++; if (bus.square_out !== 1'b0) begin n_bad++; $display("FAIL hy_1983: got %b want 0", bus.square_out); end
  endtask

  task automatic test_saturation();
    calibrate(12'd5, 12'd5);
    n_cmp++; if (bus.thr !== 12'd5) begin n_bad++; $display("FAIL sat_thr5: got %0d want 5", bus.thr); end
    send_n(12'd4095, 3);
    n_cmp++; if (bus.square_out !== 1'b1) begin n_bad++; $display("FAIL sat_rise5: got %b want 1", bus.square_out); end
    send_n(12'd0, 5);
    n_cmp++; if (bus.square_out !== 1'b1) begin n_bad++; $display("FAIL sat_lo_floor: got %b want 1", bus.square_out); end
    calibrate(12'd4090, 12'd4090);
    n_cmp++; if (bus.thr !== 12'd4090) begin n_bad++; $display("FAIL sat_thr4090: got %0d want 4090", bus.thr); end
    send_n(12'd4095, 5);
    n_cmp++; if (bus.square_out !== 1'b0) begin n_bad++; $display("FAIL sat_hi_ceiling: got %b want 0", bus.square_out); end
  endtask

  task automatic test_reset_mid();
    calibrate(12'd1000, 12'd3000);
    send_n(12'd3000, 500);
    n_cmp++; if (bus.square_out !== 1'b1) begin n_bad++; $display("FAIL mid_pre_high: got %b want 1", bus.square_out); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.square_out !== 1'b0) begin n_bad++; $display("FAIL mid_square: got %b want 0", bus.square_out); end
    n_cmp++; if (bus.thr !== 12'd0) begin n_bad++; $display("FAIL mid_thr: got %0d want 0", bus.thr); end
    n_cmp++; if (bus.thr_valid !== 1'b0) begin n_bad++; $display("FAIL mid_thr_valid: got %b want 0", bus.thr_valid); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.adc_valid = 1'b1;
      bus.adc_data  = 12'd4095;
    end
    @(negedge clk);
    bus.adc_valid = 1'b0;
    rst_n = 1'b1;
    send_n(12'd3000, 1023);
    n_cmp++; if (bus.thr_valid !== 1'b0) begin n_bad++; $display("FAIL mid_tv_1023: got %b want 0", bus.thr_valid); end
    send(12'd3000, 2);
    n_cmp++; if (bus.thr_valid !== 1'b1) begin n_bad++; $display("FAIL mid_tv_1024: got %b want 1", bus.thr_valid); end
    n_cmp++; if (bus.thr !== 12'd3000) begin n_bad++; $display("FAIL mid_thr_new: got %0d want 3000", bus.thr); end
    n_cmp++; if (bus.square_out !== 1'b0) begin n_bad++; $display("FAIL mid_square_idle: got %b want 0", bus.square_out); end
  endtask

  initial begin
    test_reset();
    test_calibration();
    test_tracking();
    test_glitch();
    test_hysteresis();
    test_saturation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
